// File: rtl/dnn_acc_pkg.sv
// Shared constants and helpers for the accelerator data path (request generator,
// response side, write-back).
package dnn_acc_pkg;

  localparam int unsigned DATA_WIDTH_DEF  = 32;
  localparam int unsigned BRAM_RD_LAT_DEF = 2;

  // Ceiling log2; returns 0 for v <= 1.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((r < 32) && ((64'd1 << r) < 64'(v))) r++;
    return r;
  endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// Synchronous first-word-fall-through FIFO on a register array; a push is
// accepted when full only if a pop happens in the same cycle.
module sync_fifo_fwft
  import dnn_acc_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned DEPTH      = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clr,
  input  logic                       push,
  input  logic                       pop,
  input  logic [DATA_WIDTH-1:0]      din,
  output logic [DATA_WIDTH-1:0]      dout,
  output logic [clog2(DEPTH):0]      count
);

  localparam int unsigned AW = clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic                  empty;
  logic                  full;
  logic                  pop_ok;
  logic                  push_ok;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);

  // Head word is forced to zero while empty so the output is defined out of reset.
  assign dout = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok && !rst && !clr) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/data_resp.sv
// Read-response side: tracks issued RAM reads, captures data after RD_LATENCY and
// buffers it with credit-based stall. Optional statistics under DATA_RESP_STAT_EN.
module data_resp
  import dnn_acc_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned RD_LATENCY = BRAM_RD_LAT_DEF,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_rden,
  input  logic                  i_end,
  input  logic [DATA_WIDTH-1:0] i_rdata,
  output logic                  o_stall,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_valid,
  input  logic                  i_ready
`ifdef DATA_RESP_STAT_EN
  ,
  output logic [31:0]           o_pop_cnt,
  output logic [31:0]           o_stall_cyc
`endif
);

  localparam int unsigned CW = clog2(FIFO_DEPTH) + 1;
  localparam int unsigned SW = CW + 1;

  logic                  clr;
  logic [RD_LATENCY-1:0] vpipe;
  logic                  land;
  logic                  pop;
  logic [CW-1:0]         inflight;
  logic [CW-1:0]         count;

  assign clr  = rst | i_end;
  assign land = vpipe[RD_LATENCY-1];
  assign pop  = o_valid & i_ready;

  // Valid pipe mirrors the RAM read latency; clearing it discards in-flight data.
  always_ff @(posedge clk) begin
    if (clr) vpipe <= '0;
    else     vpipe <= RD_LATENCY'({vpipe, i_rden});
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      inflight <= '0;
    end else begin
      case ({i_rden, land})
        2'b10:   inflight <= inflight + CW'(1);
        2'b01:   inflight <= inflight - CW'(1);
        default: inflight <= inflight;
      endcase
    end
  end

  sync_fifo_fwft #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clr   (i_end),
    .push  (land),
    .pop   (pop),
    .din   (i_rdata),
    .dout  (o_data),
    .count (count)
  );

  // Credit check uses only registered state, so no path from i_rden/i_ready.
  assign o_valid = (count != '0);
  assign o_stall = (SW'(count) + SW'(inflight)) >= SW'(FIFO_DEPTH);

`ifdef DATA_RESP_STAT_EN
  always_ff @(posedge clk) begin
    if (clr) begin
      o_pop_cnt   <= '0;
      o_stall_cyc <= '0;
    end else begin
      if (pop)     o_pop_cnt   <= o_pop_cnt + 32'd1;
      if (o_stall) o_stall_cyc <= o_stall_cyc + 32'd1;
    end
  end
`endif

  a_no_rden_on_stall: assert property (@(posedge clk) disable iff (clr) !(i_rden && o_stall));

endmodule

// File: tb/tb_data_resp.sv
// Directed self-checking bench for data_resp (default parameters), with a
// request-generator model (rden = req & ~stall) and a fixed-latency RAM model.
module tb_data_resp;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_rden;
  logic        i_end;
  logic        i_ready;
  logic [31:0] i_rdata;
  logic        o_stall;
  logic [31:0] o_data;
  logic        o_valid;
`ifdef DATA_RESP_STAT_EN
  logic [31:0] o_pop_cnt;
  logic [31:0] o_stall_cyc;
`endif

  logic [31:0] wdata;
  logic [31:0] ap0;
  logic [31:0] ap1;
  int          n_checks = 0;
  int          n_fail   = 0;
  int          pulses;
  int          issued;
  int          got;
  int          first;
  int          last;
  int          stall_seen;

  always #5 clk = ~clk;

  // RAM model: data for a read issued in cycle t is presented in cycle t+2.
  always @(posedge clk) begin
    ap0 <= i_rden ? wdata : 32'hDEAD_BEEF;
    ap1 <= ap0;
  end
  assign i_rdata = ap1;

  data_resp dut (
    .clk         (clk),
    .rst         (rst),
    .i_rden      (i_rden),
    .i_end       (i_end),
    .i_rdata     (i_rdata),
    .o_stall     (o_stall),
    .o_data      (o_data),
    .o_valid     (o_valid),
    .i_ready     (i_ready)
`ifdef DATA_RESP_STAT_EN
    ,
    .o_pop_cnt   (o_pop_cnt),
    .o_stall_cyc (o_stall_cyc)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; i_rden = 1'b0; i_end = 1'b0; i_ready = 1'b0; wdata = '0;
    repeat (3) @(negedge clk);
    check("rst_valid", 32'(o_valid), 32'd0);
    check("rst_stall", 32'(o_stall), 32'd0);
    check("rst_data", o_data, 32'd0);
    check("rst_count", 32'(dut.count), 32'd0);
    check("rst_inflight", 32'(dut.inflight), 32'd0);
`ifdef DATA_RESP_STAT_EN
    check("rst_pop_cnt", o_pop_cnt, 32'd0);
    check("rst_stall_cyc", o_stall_cyc, 32'd0);
`endif
    rst = 1'b0;
    @(negedge clk);

    // Single read: valid for exactly one cycle, RD_LATENCY+1 after the read.
    i_ready = 1'b1; i_rden = 1'b1; wdata = 32'hA5A5_0001;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      i_rden = 1'b0;
      check("single_valid", 32'(o_valid), 32'(k == 3));
      if (k == 3) check("single_data", o_data, 32'hA5A5_0001);
    end

    // Back-pressure to full with request held.
    i_end = 1'b1; @(negedge clk); i_end = 1'b0;
    i_ready = 1'b0; pulses = 0;
    for (int c = 0; c < 18; c++) begin
      i_rden = !o_stall; wdata = 32'(pulses);
      if (i_rden) pulses++;
      @(negedge clk);
    end
    check("bp_pulses", 32'(pulses), 32'd8);
    check("bp_stall", 32'(o_stall), 32'd1);
    check("bp_count", 32'(dut.count), 32'd8);
    check("bp_inflight", 32'(dut.inflight), 32'd0);
    check("bp_head", o_data, 32'd0);
`ifdef DATA_RESP_STAT_EN
    check("stat_stall_cyc", o_stall_cyc, 32'd10);
    check("stat_pop_full", o_pop_cnt, 32'd0);
`endif

    // Release from full: one pop frees one credit for exactly one read.
    i_ready = 1'b1; i_rden = !o_stall;
    if (i_rden) pulses++;
    @(negedge clk);
    i_ready = 1'b0;
    check("rel_stall_drop", 32'(o_stall), 32'd0);
    check("rel_count7", 32'(dut.count), 32'd7);
    i_rden = !o_stall; wdata = 32'd8;
    if (i_rden) pulses++;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("rel_stall_again", 32'(o_stall), 32'd1);
      i_rden = !o_stall;
      if (i_rden) pulses++;
      if (k == 1) check("rel_count_wait", 32'(dut.count), 32'd7);
    end
    check("rel_pulses", 32'(pulses), 32'd9);
    check("rel_count8", 32'(dut.count), 32'd8);
    i_rden = 1'b0;

    // Drain the eight buffered words in order.
    i_ready = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      check("drain_valid", 32'(o_valid), 32'd1);
      check("drain_data", o_data, 32'(k));
      @(negedge clk);
    end
    check("drain_empty", 32'(o_valid), 32'd0);
    check("drain_stall", 32'(o_stall), 32'd0);
`ifdef DATA_RESP_STAT_EN
    check("stat_pop_cnt", o_pop_cnt, 32'd9);
`endif

    // Full-rate streaming of 100 address-valued words.
    issued = 0; got = 0; first = -1; last = -1; stall_seen = 0;
    for (int c = 0; c < 110; c++) begin
      if (o_valid) begin
        check("stream_data", o_data, 32'(got));
        if (got == 0) first = c;
        last = c;
        got++;
      end
      if (o_stall) stall_seen++;
      i_rden = (issued < 100) && !o_stall;
      wdata = 32'(issued);
      if (i_rden) issued++;
      @(negedge clk);
    end
    i_rden = 1'b0;
    check("stream_count", 32'(got), 32'd100);
    check("stream_no_stall", 32'(stall_seen), 32'd0);
    check("stream_first", 32'(first), 32'd3);
    check("stream_rate", 32'(last - first), 32'd99);
    check("stream_idle", 32'(o_valid), 32'd0);

    // Flush with three buffered and two in flight.
    i_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      i_rden = 1'b1; wdata = 32'(100 + c);
      @(negedge clk);
    end
    i_rden = 1'b0;
    check("flush_pre_count", 32'(dut.count), 32'd3);
    check("flush_pre_inflight", 32'(dut.inflight), 32'd2);
    check("flush_pre_head", o_data, 32'd100);
    i_end = 1'b1;
    @(negedge clk);
    i_end = 1'b0;
    check("flush_valid", 32'(o_valid), 32'd0);
    check("flush_stall", 32'(o_stall), 32'd0);
    check("flush_inflight", 32'(dut.inflight), 32'd0);
    for (int k = 0; k < 3; k++) begin
      check("flush_count", 32'(dut.count), 32'd0);
      @(negedge clk);
    end
    check("flush_late_valid", 32'(o_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/data_resp.md
# data_resp

Response-side companion to the data read-request generator. It tracks read enables issued to the data block RAM, captures the RAM's read data after a fixed read latency, and buffers it in a small first-word-fall-through FIFO with a valid/ready output to the compute datapath. It drives a stall back to the request generator so that every issued read always has a guaranteed FIFO slot.

## Interface
- DATA_WIDTH, 32: width of RAM read data and output data.
- RD_LATENCY, 2: cycles from `i_rden` high to valid `i_rdata`; legal range 1..4.
- FIFO_DEPTH, 8: buffer entries; power of two, 2..64.

- clk  in  1  clock; all logic is on the rising edge.
- rst  in  1  reset; synchronous, active-high.
- i_rden  in  1  read enable, as issued to the RAM by the request generator.
- i_end  in  1  end of layer/tile; synchronous flush.
- i_rdata  in  DATA_WIDTH  RAM read data.
- o_stall  out  1  request-side stall; must be connected to the request generator's stall input.
- o_data  out  DATA_WIDTH  FIFO head word.
- o_valid  out  1  `o_data` is valid.
- i_ready  in  1  downstream accepts the head word.

## Operation
- Valid pipe: a shift register RD_LATENCY bits deep, loaded with `i_rden` each cycle. Its last stage is `land`.
- When `land` = 1, `i_rdata` is pushed into the FIFO in that cycle.
- `inflight` counter, width clog2(FIFO_DEPTH)+1:
  - +1 on `i_rden`, −1 on `land`.
  - Both in the same cycle leave it unchanged.
- `count` counter, same width: FIFO occupancy.
  - +1 on push, −1 on pop.
  - Push and pop together leave it unchanged.
- Pop: `o_valid & i_ready`.
- `o_valid = (count != 0)`. `o_data` = FIFO head (first-word fall-through); its value is don't-care when `o_valid` = 0.
- `o_stall = (count + inflight) >= FIFO_DEPTH`.
  - Decoded only from registers; it has no combinational path from `i_rden` or `i_ready`.
  - With the stall connected, `count + inflight <= FIFO_DEPTH` always holds, so a push never finds the FIFO full.
- `i_rden` while `o_stall` = 1 is a protocol violation. The read is still counted, but the landing word is dropped if the FIFO is full. Assertion only; no recovery is provided.
- `i_end`, and `rst`:
  - Clear the valid pipe, `inflight`, `count`, and the FIFO pointers in the same cycle.
  - RAM data still in flight is discarded, because its pipe bits are cleared.
  - `rst` and `i_end` have identical effect; if both are high, the result is still a clear.
  - `i_rden`, push and pop in a clear cycle are ignored.
- FIFO pointers wrap modulo FIFO_DEPTH.

## Timing
- Reset values: `o_valid` = 0, `o_stall` = 0, `o_data` = 0, and all counters = 0.
- Read latency:
  - `i_rden` at cycle t; `i_rdata` is sampled at the end of cycle t+RD_LATENCY.
  - `o_valid` first goes high in cycle t+RD_LATENCY+1.
  - Total read-to-valid latency is RD_LATENCY+1 cycles.
- A pop in cycle t presents the next word in cycle t+1. Sustained throughput is one word per cycle when `i_ready` = 1.
- Stall:
  - The `i_rden` that makes `count + inflight` reach FIFO_DEPTH causes `o_stall` = 1 from the next cycle.
  - A pop in cycle t deasserts `o_stall` in cycle t+1 (unless a concurrent `land`-free increment refills the credit).
- FIFO full with a simultaneous pop and push: both occur and `count` is unchanged.
- Empty FIFO with a push: `o_valid` rises next cycle. There is no same-cycle bypass.

## Configuration
- DATA_RESP_STAT_EN defined:
  - Adds output `o_pop_cnt` [31:0], counting words popped (wraps at 2^32).
  - Adds output `o_stall_cyc` [31:0], counting cycles with `o_stall` = 1.
  - Both reset to 0 on `rst` or `i_end`.
- DATA_RESP_STAT_EN undefined: neither port nor its counter exists, and all other behaviour is identical.

## Structure
- Shared package `dnn_acc_pkg`:
  - the `clog2` constant function;
  - default constants `DATA_WIDTH_DEF` = 32 and `BRAM_RD_LAT_DEF` = 2, shared with the request generator.
- Sub-module `sync_fifo_fwft` (parameters DATA_WIDTH, DEPTH):
  - ports push/pop/din/dout/count/clr;
  - register-array storage;
  - reusable by the write-back path.
- Top level `data_resp` holds the valid pipe, the `inflight` counter, the stall decode, and the optional statistics.

## Test plan
- Single read, RD_LATENCY=2:
  - Stimulus: `i_rden` at cycle 5; `i_rdata` = 0xA5A5_0001 at cycle 7; `i_ready` = 1.
  - Required: `o_valid` = 1 in cycle 8 only, with `o_data` = 0xA5A5_0001.
- Back-pressure to full, FIFO_DEPTH=8:
  - Stimulus: `i_ready` = 0, with request generator `i_req` = 1 held.
  - Required: exactly 8 `i_rden` pulses, then `o_stall` = 1 held; `count` = 8 and `inflight` = 0.
- Full streaming:
  - Stimulus: `i_ready` = 1, 100 consecutive reads of address-valued data.
  - Required: 100 words out in order (0..99), `o_stall` never asserted, one word per cycle after the first.
- Release from full:
  - Stimulus: FIFO full, then `i_ready` = 1 for 1 cycle.
  - Required: `o_stall` drops next cycle, one new `i_rden` is accepted, and `count` returns to 8 after RD_LATENCY+1 cycles.
- Flush mid-flight:
  - Stimulus: 3 words buffered and 2 in flight, then `i_end` pulsed.
  - Required: `o_valid` = 0 next cycle, the 2 late `i_rdata` words are not pushed, and `o_stall` = 0.
- Statistics (DATA_RESP_STAT_EN):
  - Stimulus: the back-pressure test with 10 stalled cycles, then drain.
  - Required: `o_stall_cyc` = 10 and `o_pop_cnt` = 8.
